// File: rtl/switch_press_decoder.sv
// switch_press_decoder
// Per-button conditioning for the Go-board switches. Each channel has a
// two-flop synchroniser, a debounce filter and a press classifier. Every
// channel emits a registered one-cycle pulse on the release of a short press
// and another when a hold reaches the long-press limit. Channels are fully
// independent; any priority between them is resolved downstream.
module switch_press_decoder #(
  parameter int NUM_SWITCHES     = 4,
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_LIMIT = 25000000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Level,
  output logic [NUM_SWITCHES-1:0] o_Short_Press,
  output logic [NUM_SWITCHES-1:0] o_Long_Press
);

  localparam int DB_W   = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);

  // The debounce counter flips the level when it has already counted
  // DEBOUNCE_LIMIT-1 mismatching cycles; together with the two synchroniser
  // stages the level moves DEBOUNCE_LIMIT+2 edges after a clean raw change.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
  // Hold value that, once incremented, reaches the long-press limit.
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONG     = 2'd2
  } state_t;

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : gen_ch
    logic [1:0]        r_Sync;
    logic [DB_W-1:0]   r_Db_Count;
    logic              r_Level;
    state_t            r_State;
    state_t            w_State_Next;
    logic [HOLD_W-1:0] r_Hold;
    logic [HOLD_W-1:0] w_Hold_Next;
    logic              w_Short_Next;
    logic              w_Long_Next;
    logic              r_Short;
    logic              r_Long;

    // Two-flop synchroniser for the asynchronous raw button level.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        r_Sync <= 2'b00;
      end else begin
        r_Sync <= {r_Sync[0], i_Switch[g]};
      end
    end

    // Debounce: flip the level only after an unbroken run of mismatches;
    // any return to the current level restarts the count.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        r_Db_Count <= '0;
        r_Level    <= 1'b0;
      end else if (r_Sync[1] == r_Level) begin
        r_Db_Count <= '0;
      end else if (r_Db_Count == DB_LAST) begin
        r_Level    <= r_Sync[1];
        r_Db_Count <= '0;
      end else begin
        r_Db_Count <= r_Db_Count + 1'b1;
      end
    end

    // Classifier state, hold counter and registered event pulses.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
        r_State <= ST_RELEASED;
        r_Hold  <= '0;
        r_Short <= 1'b0;
        r_Long  <= 1'b0;
      end else begin
        r_State <= w_State_Next;
        r_Hold  <= w_Hold_Next;
        r_Short <= w_Short_Next;
        r_Long  <= w_Long_Next;
      end
    end

    // Next-state logic: short pulse on release from HELD, long pulse when the
    // hold reaches the limit; LONG swallows the release silently.
    always_comb begin
      w_State_Next = r_State;
      w_Hold_Next  = r_Hold;
      w_Short_Next = 1'b0;
      w_Long_Next  = 1'b0;
      case (r_State)
        ST_RELEASED: begin
          w_Hold_Next = HOLD_ZERO;
          if (r_Level) begin
            w_State_Next = ST_HELD;
            w_Hold_Next  = HOLD_ONE;
          end
        end
        ST_HELD: begin
          if (r_Level) begin
            if (r_Hold >= HOLD_PRE) begin
              w_Hold_Next  = HOLD_MAX;
              w_Long_Next  = 1'b1;
              w_State_Next = ST_LONG;
            end else begin
              w_Hold_Next = r_Hold + 1'b1;
            end
          end else begin
            w_Short_Next = 1'b1;
            w_State_Next = ST_RELEASED;
            w_Hold_Next  = HOLD_ZERO;
          end
        end
        ST_LONG: begin
          if (!r_Level) begin
            w_State_Next = ST_RELEASED;
            w_Hold_Next  = HOLD_ZERO;
          end
        end
        default: begin
          w_State_Next = ST_RELEASED;
          w_Hold_Next  = HOLD_ZERO;
        end
      endcase
    end

    assign o_Level[g]       = r_Level;
    assign o_Short_Press[g] = r_Short;
    assign o_Long_Press[g]  = r_Long;
  end

endmodule

// File: tb/tb_switch_press_decoder.sv
// tb_switch_press_decoder
// Directed scenarios with DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10. Each scenario
// pushes the expected per-edge output vectors (derived from the documented
// edge timing) into a queue; a negedge checker pops and compares them.
module tb_switch_press_decoder;
  localparam int NSW = 4;
  localparam int DL  = 4;
  localparam int LPL = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NSW-1:0] sw  = '0;
  logic [NSW-1:0] lvl;
  logic [NSW-1:0] sp;
  logic [NSW-1:0] lp;

  always #5 clk = ~clk;

  switch_press_decoder #(
    .NUM_SWITCHES    (NSW),
    .DEBOUNCE_LIMIT  (DL),
    .LONG_PRESS_LIMIT(LPL)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Switch     (sw),
    .o_Level      (lvl),
    .o_Short_Press(sp),
    .o_Long_Press (lp)
  );

  typedef struct {
    int             e;
    logic [NSW-1:0] lvl;
    logic [NSW-1:0] sp;
    logic [NSW-1:0] lp;
  } exp_t;

  exp_t  sb[$];
  exp_t  cx;
  int    edge_n   = 0;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    base_e   = 0;
  string cur_tag  = "init";

  // Per-channel expected events (edge numbers, -1 = never).
  int lon[NSW];
  int loff[NSW];
  int spe[NSW];
  int lpe[NSW];

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void check4(string tag, logic [NSW-1:0] act, logic [NSW-1:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endfunction

  // Scoreboard checker: compare every queued expectation on its edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_n) begin
      cx = sb.pop_front();
      n_checks++;
      assert (cx.e == edge_n) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s sb_timing: observed edge %0d expected edge %0d", cur_tag, edge_n, cx.e);
      end
      check4($sformatf("%s+%0d o_Level", cur_tag, cx.e - base_e), lvl, cx.lvl);
      check4($sformatf("%s+%0d o_Short_Press", cur_tag, cx.e - base_e), sp, cx.sp);
      check4($sformatf("%s+%0d o_Long_Press", cur_tag, cx.e - base_e), lp, cx.lp);
    end
  end

  task automatic clear_exp();
    for (int i = 0; i < NSW; i++) begin
      lon[i]  = -1;
      loff[i] = -1;
      spe[i]  = -1;
      lpe[i]  = -1;
    end
  endtask

  task automatic push_window(int e0, int n);
    exp_t x;
    for (int k = e0 + 1; k <= e0 + n; k++) begin
      x.e = k;
      for (int i = 0; i < NSW; i++) begin
        x.lvl[i] = (lon[i] >= 0) && (k >= lon[i]) && ((loff[i] < 0) || (k < loff[i]));
        x.sp[i]  = (k == spe[i]);
        x.lp[i]  = (k == lpe[i]);
      end
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    assert (sb.size() == 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s drain: observed %0d pending expected 0", cur_tag, sb.size());
    end
  endtask

  task automatic start(string tag);
    @(negedge clk);
    cur_tag = tag;
    base_e  = edge_n;
    clear_exp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    // Reset state with clock running.
    repeat (2) @(negedge clk);
    check4("reset o_Level", lvl, 4'b0000);
    check4("reset o_Short_Press", sp, 4'b0000);
    check4("reset o_Long_Press", lp, 4'b0000);
    rst = 1'b0;

    // Idle: nothing happens.
    start("idle");
    push_window(base_e, 5);
    drain();

    // Short press on channel 0.
    start("short");
    e = base_e;
    lon[0] = e + 6; loff[0] = e + 14; spe[0] = e + 15;
    push_window(e, 25);
    sw[0] = 1'b1;
    repeat (8) @(negedge clk);
    sw[0] = 1'b0;
    drain();

    // Bounce on channel 1, then a settled short press.
    start("bounce");
    e = base_e;
    lon[1] = e + 18; loff[1] = e + 26; spe[1] = e + 27;
    push_window(e, 35);
    sw[1] = 1'b1; repeat (3) @(negedge clk);
    sw[1] = 1'b0; repeat (3) @(negedge clk);
    sw[1] = 1'b1; repeat (3) @(negedge clk);
    sw[1] = 1'b0; repeat (3) @(negedge clk);
    sw[1] = 1'b1; repeat (8) @(negedge clk);
    sw[1] = 1'b0;
    drain();

    // Long press on channel 2: one long pulse, silent release.
    start("long");
    e = base_e;
    lon[2] = e + 6; loff[2] = e + 36; lpe[2] = e + 16;
    push_window(e, 45);
    sw[2] = 1'b1;
    repeat (30) @(negedge clk);
    sw[2] = 1'b0;
    drain();

    // Channels 0 and 3 pressed and released together.
    start("simul");
    e = base_e;
    lon[0] = e + 6; loff[0] = e + 11; spe[0] = e + 12;
    lon[3] = e + 6; loff[3] = e + 11; spe[3] = e + 12;
    push_window(e, 20);
    sw = 4'b1001;
    repeat (5) @(negedge clk);
    sw = 4'b0000;
    drain();

    // Three-cycle glitch on channel 3 is rejected.
    start("glitch");
    push_window(base_e, 15);
    sw[3] = 1'b1;
    repeat (3) @(negedge clk);
    sw[3] = 1'b0;
    drain();

    // All buttons pressed, then asynchronous reset mid-press.
    start("reset_pre");
    e = base_e;
    for (int i = 0; i < NSW; i++) lon[i] = e + 6;
    push_window(e, 7);
    sw = 4'b1111;
    drain();
    #2 rst = 1'b1;
    #1;
    check4("async_reset o_Level", lvl, 4'b0000);
    check4("async_reset o_Short_Press", sp, 4'b0000);
    check4("async_reset o_Long_Press", lp, 4'b0000);
    repeat (3) @(negedge clk);
    check4("held_reset o_Level", lvl, 4'b0000);
    check4("held_reset o_Long_Press", lp, 4'b0000);
    rst = 1'b0;
    cur_tag = "reset_post";
    base_e  = edge_n;
    e = base_e;
    clear_exp();
    for (int i = 0; i < NSW; i++) begin
      lon[i] = e + 6;
      lpe[i] = e + 16;
    end
    push_window(e, 20);
    repeat (20) @(negedge clk);
    sw = 4'b0000;
    for (int i = 0; i < NSW; i++) loff[i] = e + 26;
    push_window(e + 20, 12);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/switch_press_decoder.md
Name: switch_press_decoder

Overview:
- Per-switch conditioning front end for the four Go-board push buttons; sits directly upstream of the score/counter logic and replaces the shared single debounce filter.
- Each channel synchronises, debounces and classifies presses as short (released before a hold limit) or long (held to the limit).
- Outputs are single-cycle event pulses, so the downstream counter needs no edge detection of its own.

Parameters:
- NUM_SWITCHES, 4, number of independent channels.
- DEBOUNCE_LIMIT, 250000, cycles the synchronised input must differ from the debounced level before the level flips (10 ms at 25 MHz); minimum 2.
- LONG_PRESS_LIMIT, 25000000, cycles of debounced-high hold that qualify a long press (1 s at 25 MHz); must exceed 1.

Ports:
- i_Clk  input  1  system clock; all logic is on its rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Switch  input  NUM_SWITCHES  raw, asynchronous button levels; 1 = pressed.
- o_Level  output  NUM_SWITCHES  debounced level per channel.
- o_Short_Press  output  NUM_SWITCHES  one-cycle pulse per channel on release of a short press.
- o_Long_Press  output  NUM_SWITCHES  one-cycle pulse per channel when the hold reaches LONG_PRESS_LIMIT.

Behaviour:
- Reset: i_Reset high clears immediately, without waiting for a clock edge, every flop in every channel:
  - synchroniser flops, debounce counters and hold counters to 0;
  - o_Level, o_Short_Press and o_Long_Press to 0;
  - channel FSM to RELEASED.
- Reset mid-press: all state is discarded. A button still held when reset deasserts is re-qualified from level 0, so o_Level rises DEBOUNCE_LIMIT+2 edges later and is treated as a new press.
- Synchroniser: two flops per channel; the sync output follows i_Switch with 2 cycles of latency.
- Debounce (per channel, counter width clog2(DEBOUNCE_LIMIT)):
  - sync == o_Level: counter <= 0.
  - sync != o_Level and counter < DEBOUNCE_LIMIT-1: counter increments.
  - sync != o_Level and counter == DEBOUNCE_LIMIT-1: o_Level <= sync, counter <= 0.
  - Net latency: o_Level changes on the (DEBOUNCE_LIMIT+2)th rising edge after a clean raw transition. Any glitch back to the old level restarts the count.
- Classification FSM (per channel, hold counter width clog2(LONG_PRESS_LIMIT+1), saturating):
  - RELEASED: on o_Level rising, go to HELD with hold <= 1.
  - HELD, o_Level high: hold increments. When hold reaches LONG_PRESS_LIMIT, assert o_Long_Press for exactly that cycle and go to LONG.
  - HELD, o_Level low: assert o_Short_Press for one cycle, go to RELEASED, hold <= 0.
  - LONG: no further pulses while held, however long. On o_Level low, go to RELEASED silently (no short pulse).
- Pulse timing: both pulses are registered. Each is high for exactly one cycle, and the two never coincide on a channel.
- Channel independence: channels never interact. Multiple channels may pulse in the same cycle, and downstream logic resolves any priority.
- Unused FSM encodings recover to RELEASED.

Test Plan:
(All scenarios use DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=10.)
- Reset: hold i_Reset high for 3 cycles mid-activity, with i_Switch=4'b1111 and no clock edges -> all outputs 0 immediately. After release -> o_Level=4'b1111 exactly 6 edges later, then o_Long_Press=4'b1111 after 10 more cycles.
- Short press: i_Switch[0] high for 8 cycles, then low ->
  - o_Level[0] rises 6 edges after the press;
  - o_Level[0] falls 6 edges after the release;
  - one-cycle o_Short_Press[0] on the following edge;
  - o_Long_Press stays 0.
- Bounce: i_Switch[1] toggles 1,0,1,0 every 3 cycles, then holds high -> o_Level[1] stays 0 until 6 edges after the final rise, and exactly one press is classified.
- Long press: i_Switch[2] held for 30 cycles ->
  - o_Long_Press[2] pulses once, 10 cycles after o_Level[2] rises;
  - no o_Short_Press[2] on release.
- Simultaneous events: channels 0 and 3 pressed on the same cycle and released together after 5 cycles -> o_Short_Press=4'b1001 in a single cycle.
- Glitch rejection: a 3-cycle high pulse on i_Switch[3] -> o_Level[3], o_Short_Press[3] and o_Long_Press[3] never assert.
